// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 7-segment scanner for DIGITS BCD nibbles, sampled once per frame.
// Optional feature macro: LEADING_ZERO_BLANK_EN (leading-zero digit blanking).
module bcd_display_scanner #(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 1000,
   parameter int BLANK_CYC   = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [4*DIGITS-1:0] bcd_in,
   output logic [DIGITS-1:0]   an,
   output logic [6:0]          seg,
   output logic                frame_start
);

   localparam int PCNT_W = $clog2(REFRESH_DIV);
   localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(REFRESH_DIV - 1);
   localparam logic [PCNT_W-1:0] PCNT_BLNK = PCNT_W'(BLANK_CYC);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

   logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [4*DIGITS-1:0] snap_q, snap_d;
   logic [DIGITS-1:0]   an_q, an_d;
   logic [6:0]          seg_q, seg_d;
   logic                frame_start_q, frame_start_d;

   logic                slot_wrap;
   logic                frame_edge;
   logic [3:0]          cur_digit;
   logic [DIGITS-1:0]   idx_onehot;
   logic [DIGITS-1:0]   blank_mask;

   function automatic logic [6:0] dec7(input logic [3:0] d);
      case (d)
         4'd0:    dec7 = 7'h3F;
         4'd1:    dec7 = 7'h06;
         4'd2:    dec7 = 7'h5B;
         4'd3:    dec7 = 7'h4F;
         4'd4:    dec7 = 7'h66;
         4'd5:    dec7 = 7'h6D;
         4'd6:    dec7 = 7'h7D;
         4'd7:    dec7 = 7'h07;
         4'd8:    dec7 = 7'h7F;
         4'd9:    dec7 = 7'h6F;
         default: dec7 = 7'h40;
      endcase
   endfunction

`ifdef LEADING_ZERO_BLANK_EN
   // Bit k is set when every snapped digit from k upward is zero; digit 0 always shows.
   always_comb begin
      logic all_zero;
      blank_mask = '0;
      all_zero   = 1'b1;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         all_zero      = all_zero & (snap_q[4*k +: 4] == 4'd0);
         blank_mask[k] = all_zero;
      end
   end
`else
   assign blank_mask = '0;
`endif

   always_comb begin
      // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
      cur_digit  = 4'd0;
      idx_onehot = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx_q == IDX_W'(k)) begin
            cur_digit     = snap_q[4*k +: 4];
            idx_onehot[k] = 1'b1;
         end
      end
   end

   always_comb begin
      slot_wrap  = (pcnt_q == PCNT_LAST);
      frame_edge = slot_wrap && (idx_q == IDX_LAST);

      pcnt_d = slot_wrap ? '0 : pcnt_q + 1'b1;
      idx_d  = idx_q;
      if (slot_wrap) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end

      // bcd_in is only looked at on the frame edge, so ripple transients never show.
      snap_d        = frame_edge ? bcd_in : snap_q;
      frame_start_d = frame_edge;

      an_d  = (pcnt_q < PCNT_BLNK) ? '0 : (idx_onehot & ~blank_mask);
      seg_d = dec7(cur_digit);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt_q        <= '0;
         idx_q         <= '0;
         snap_q        <= '0;
         an_q          <= '0;
         seg_q         <= '0;
         frame_start_q <= 1'b0;
      end else begin
         pcnt_q        <= pcnt_d;
         idx_q         <= idx_d;
         snap_q        <= snap_d;
         an_q          <= an_d;
         seg_q         <= seg_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign an          = an_q;
   assign seg         = seg_q;
   assign frame_start = frame_start_q;

endmodule
